exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_stage_if.sv | 27 ++
 rtl/exe_stage.sv | 106 ++++++++++
 tb/tb_exe_stage.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// Pipeline links around the execute stage: decode->execute, execute->memory,
// the forwarding/blocking bus and the data SRAM request port.
interface exe_stage_if;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_fwd_blk_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_blk_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_fwd_blk_bus,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage.sv
// Single-cycle execute stage: operand select, one-hot ALU, data SRAM request,
// and forwarding/load-use blocking information for the decode stage.
module exe_stage (
  input  logic       clk,
  input  logic       resetn,
  exe_stage_if.slave pipe
);
  logic         es_valid;
  logic         es_ready_go;
  logic         es_allowin;
  logic [135:0] es_bus;

  logic [11:0]  alu_op;
  logic         load_op;
  logic         src1_is_sa;
  logic         src1_is_pc;
  logic         src2_is_imm;
  logic         src2_is_8;
  logic         gr_we;
  logic         mem_we;
  logic [4:0]   dest;
  logic [15:0]  imm;
  logic [31:0]  rs_value;
  logic [31:0]  rt_value;
  logic [31:0]  pc;

  logic [31:0]        src1;
  logic [31:0]        src2;
  logic signed [31:0] src2_s;
  logic [31:0]        add_res;
  logic [31:0]        sub_res;
  logic [31:0]        slt_res;
  logic [31:0]        sltu_res;
  logic [31:0]        sll_res;
  logic [31:0]        srl_res;
  logic [31:0]        sra_res;
  logic [31:0]        lui_res;
  logic [31:0]        alu_result;
  logic               dest_nz;

  assign es_ready_go = 1'b1;
  assign es_allowin  = !es_valid || (es_ready_go && pipe.ms_allowin);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= pipe.ds_to_es_valid;
    end
  end

  // The payload register needs no reset: it is only observed while es_valid is set.
  always_ff @(posedge clk) begin
    if (pipe.ds_to_es_valid && es_allowin) begin
      es_bus <= pipe.ds_to_es_bus;
    end
  end

  assign {alu_op, load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8,
          gr_we, mem_we, dest, imm, rs_value, rt_value, pc} = es_bus;

  assign src1 = src1_is_sa  ? {27'b0, imm[10:6]} :
                src1_is_pc  ? pc                 : rs_value;
  assign src2 = src2_is_imm ? {{16{imm[15]}}, imm} :
                src2_is_8   ? 32'd8              : rt_value;
  assign src2_s = src2;

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'b0, src1 < src2};
  assign sll_res  = src2 << src1[4:0];
  assign srl_res  = src2 >> src1[4:0];
  assign sra_res  = src2_s >>> src1[4:0];
  assign lui_res  = {src2[15:0], 16'b0};

  // alu_op is one-hot, so an AND-OR mux suffices and an empty op yields zero.
  assign alu_result = ({32{alu_op[0]}}  & add_res)
                    | ({32{alu_op[1]}}  & sub_res)
                    | ({32{alu_op[2]}}  & slt_res)
                    | ({32{alu_op[3]}}  & sltu_res)
                    | ({32{alu_op[4]}}  & (src1 & src2))
                    | ({32{alu_op[5]}}  & ~(src1 | src2))
                    | ({32{alu_op[6]}}  & (src1 | src2))
                    | ({32{alu_op[7]}}  & (src1 ^ src2))
                    | ({32{alu_op[8]}}  & sll_res)
                    | ({32{alu_op[9]}}  & srl_res)
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & lui_res);

  assign dest_nz = |dest;

  assign pipe.es_allowin     = es_allowin;
  assign pipe.es_to_ms_valid = es_valid && es_ready_go;
  assign pipe.es_to_ms_bus   = {load_op, gr_we, dest, alu_result, pc};

  assign pipe.es_fwd_blk_bus = {es_valid && gr_we && !load_op && dest_nz,
                                dest, alu_result,
                                es_valid && load_op && dest_nz};

  // Gating with ms_allowin keeps a stalled store from writing more than once.
  assign pipe.data_sram_en    = es_valid && pipe.ms_allowin && (load_op || mem_we);
  assign pipe.data_sram_wen   = (es_valid && pipe.ms_allowin && mem_we) ? 4'hf : 4'h0;
  assign pipe.data_sram_addr  = alu_result;
  assign pipe.data_sram_wdata = rt_value;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus randomized traffic checked
// against an instruction-level reference model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic resetn;
  exe_stage_if ifc ();

  exe_stage dut (.clk(clk), .resetn(resetn), .pipe(ifc));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic         m_valid;
  logic [135:0] m_ins;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4,
                 OP_NOR = 5, OP_OR = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9,
                 OP_SRA = 10, OP_LUI = 11, OP_NONE = 12;

  function automatic logic [135:0] mk(input int op, input logic ld, sa, ispc, isimm, is8,
                                      gwe, mwe, input logic [4:0] dst, input logic [15:0] im,
                                      input logic [31:0] rs, rt, pcv);
    logic [11:0] ohot;
    ohot = (op == OP_NONE) ? 12'd0 : (12'd1 << op);
    return {ohot, ld, sa, ispc, isimm, is8, gwe, mwe, dst, im, rs, rt, pcv};
  endfunction

  // Instruction semantics computed directly from the field meanings.
  function automatic logic [31:0] ref_alu(input logic [135:0] b);
    logic [31:0] a, c;
    logic [15:0] im;
    im = b[111:96];
    if (b[122])      a = 32'(im[10:6]);
    else if (b[121]) a = b[31:0];
    else             a = b[95:64];
    if (b[120])      c = 32'($signed(im));
    else if (b[119]) c = 32'd8;
    else             c = b[63:32];
    case (b[135:124])
      12'h001: return a + c;
      12'h002: return a - c;
      12'h004: return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
      12'h008: return (a < c) ? 32'd1 : 32'd0;
      12'h010: return a & c;
      12'h020: return ~(a | c);
      12'h040: return a | c;
      12'h080: return a ^ c;
      12'h100: return c << a[4:0];
      12'h200: return c >> a[4:0];
      12'h400: return 32'($signed(c) >>> a[4:0]);
      12'h800: return {c[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!resetn) m_valid = 1'b0;
    else if (!m_valid || ifc.ms_allowin) begin
      if (ifc.ds_to_es_valid) m_ins = ifc.ds_to_es_bus;
      m_valid = ifc.ds_to_es_valid;
    end
    #1;
  endtask

  task automatic drive(input logic dv, input logic [135:0] b, input logic ms);
    ifc.ds_to_es_valid = dv;
    ifc.ds_to_es_bus   = b;
    ifc.ms_allowin     = ms;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b1, mk(OP_ADD, 0, 0, 0, 0, 0, 1, 1, 5'd1, 16'h0, 32'd1, 32'd2, 32'h0), 1'b0);
    tick(); tick();
    drive(1'b1, ifc.ds_to_es_bus, 1'b1);
    n_checks++; if (ifc.es_allowin !== 1'b1) begin n_errors++; $display("FAIL rst_allowin got %b exp 1", ifc.es_allowin); end
    n_checks++; if (ifc.es_to_ms_valid !== 1'b0) begin n_errors++; $display("FAIL rst_to_ms_valid got %b exp 0", ifc.es_to_ms_valid); end
    n_checks++; if (ifc.data_sram_en !== 1'b0 || ifc.data_sram_wen !== 4'h0) begin n_errors++; $display("FAIL rst_sram got en=%b wen=%h exp 0/0", ifc.data_sram_en, ifc.data_sram_wen); end
    n_checks++; if (ifc.es_fwd_blk_bus[38] !== 1'b0 || ifc.es_fwd_blk_bus[0] !== 1'b0) begin n_errors++; $display("FAIL rst_fwd_blk got %b%b exp 00", ifc.es_fwd_blk_bus[38], ifc.es_fwd_blk_bus[0]); end
    drive(1'b0, '0, 1'b1);
    resetn = 1'b1;
    tick();
    n_checks++; if (ifc.es_to_ms_valid !== 1'b0 || ifc.es_allowin !== 1'b1) begin n_errors++; $display("FAIL post_rst got valid=%b allowin=%b exp 0/1", ifc.es_to_ms_valid, ifc.es_allowin); end
  endtask

  task automatic test_addu();
    drive(1'b1, mk(OP_ADD, 0, 0, 0, 0, 0, 1, 0, 5'd3, 16'h0, 32'd5, 32'd7, 32'h100), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (ifc.es_to_ms_bus[63:32] !== 32'd12) begin n_errors++; $display("FAIL addu_result got %h exp 0000000c", ifc.es_to_ms_bus[63:32]); end
    n_checks++; if (ifc.es_fwd_blk_bus !== {1'b1, 5'd3, 32'd12, 1'b0}) begin n_errors++; $display("FAIL addu_fwd got %h exp %h", ifc.es_fwd_blk_bus, {1'b1, 5'd3, 32'd12, 1'b0}); end
    n_checks++; if (ifc.es_to_ms_valid !== 1'b1) begin n_errors++; $display("FAIL addu_valid got %b exp 1", ifc.es_to_ms_valid); end
    tick();
    n_checks++; if (ifc.es_to_ms_valid !== 1'b0 || ifc.es_fwd_blk_bus[38] !== 1'b0) begin n_errors++; $display("FAIL empty_after got valid=%b fwd=%b exp 0/0", ifc.es_to_ms_valid, ifc.es_fwd_blk_bus[38]); end
  endtask

  task automatic test_sw_stall();
    int writes = 0;
    drive(1'b1, mk(OP_ADD, 0, 0, 0, 1, 0, 0, 1, 5'd0, 16'hfffc, 32'h1000, 32'hdeadbeef, 32'h200), 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(OP_OR, 0, 0, 0, 0, 0, 1, 0, 5'd9, 16'h0, 32'h1, 32'h2, 32'h300), 1'b0);
      if (ifc.data_sram_wen != 4'h0) writes++;
      n_checks++; if (ifc.data_sram_wen !== 4'h0 || ifc.es_allowin !== 1'b0) begin n_errors++; $display("FAIL sw_stall cycle %0d got wen=%h allowin=%b exp 0/0", i, ifc.data_sram_wen, ifc.es_allowin); end
      tick();
    end
    drive(1'b0, '0, 1'b1);
    if (ifc.data_sram_wen != 4'h0) writes++;
    n_checks++; if (ifc.data_sram_wen !== 4'hf || ifc.data_sram_addr !== 32'h0ffc || ifc.data_sram_wdata !== 32'hdeadbeef)
      begin n_errors++; $display("FAIL sw_write got wen=%h addr=%h wdata=%h exp f/00000ffc/deadbeef", ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata); end
    tick();
    if (ifc.data_sram_wen != 4'h0) writes++;
    n_checks++; if (writes !== 1) begin n_errors++; $display("FAIL sw_write_count got %0d exp 1", writes); end
  endtask

  task automatic test_lw();
    drive(1'b1, mk(OP_ADD, 1, 0, 0, 1, 0, 1, 0, 5'd8, 16'h0004, 32'h2000, 32'h0, 32'h400), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (ifc.es_fwd_blk_bus[0] !== 1'b1 || ifc.es_fwd_blk_bus[38] !== 1'b0) begin n_errors++; $display("FAIL lw_blk_fwd got blk=%b fwd=%b exp 1/0", ifc.es_fwd_blk_bus[0], ifc.es_fwd_blk_bus[38]); end
    n_checks++; if (ifc.data_sram_en !== 1'b1 || ifc.data_sram_wen !== 4'h0) begin n_errors++; $display("FAIL lw_sram got en=%b wen=%h exp 1/0", ifc.data_sram_en, ifc.data_sram_wen); end
    n_checks++; if (ifc.es_to_ms_bus[70] !== 1'b1 || ifc.data_sram_addr !== 32'h2004) begin n_errors++; $display("FAIL lw_bus got rfm=%b addr=%h exp 1/00002004", ifc.es_to_ms_bus[70], ifc.data_sram_addr); end
    tick();
  endtask

  task automatic test_jal();
    drive(1'b1, mk(OP_ADD, 0, 0, 1, 0, 1, 1, 0, 5'd31, 16'h0, 32'h0, 32'h0, 32'hbfc00010), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (ifc.es_to_ms_bus[63:32] !== 32'hbfc00018 || ifc.es_to_ms_bus[68:64] !== 5'd31)
      begin n_errors++; $display("FAIL jal got result=%h dest=%0d exp bfc00018/31", ifc.es_to_ms_bus[63:32], ifc.es_to_ms_bus[68:64]); end
    tick();
  endtask

  task automatic test_shift_cmp();
    drive(1'b1, mk(OP_SRA, 0, 1, 0, 0, 0, 1, 0, 5'd2, 16'h0100, 32'h0, 32'h80000000, 32'h0), 1'b1);
    tick();
    drive(1'b1, mk(OP_SLTU, 0, 0, 0, 0, 0, 1, 0, 5'd2, 16'h0, 32'd1, 32'hffffffff, 32'h0), 1'b1);
    n_checks++; if (ifc.es_to_ms_bus[63:32] !== 32'hf8000000) begin n_errors++; $display("FAIL sra got %h exp f8000000", ifc.es_to_ms_bus[63:32]); end
    tick();
    drive(1'b1, mk(OP_SLT, 0, 0, 0, 0, 0, 1, 0, 5'd2, 16'h0, 32'd1, 32'hffffffff, 32'h0), 1'b1);
    n_checks++; if (ifc.es_to_ms_bus[63:32] !== 32'd1) begin n_errors++; $display("FAIL sltu got %h exp 1", ifc.es_to_ms_bus[63:32]); end
    tick();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (ifc.es_to_ms_bus[63:32] !== 32'd0) begin n_errors++; $display("FAIL slt got %h exp 0", ifc.es_to_ms_bus[63:32]); end
    tick();
  endtask

  task automatic test_random();
    logic [135:0] b;
    logic [31:0]  r;
    logic         ld, mw, gw, en_e;
    logic [4:0]   d;
    for (int n = 0; n < 400; n++) begin
      b = mk(int'($urandom_range(0, 12)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             16'($urandom), $urandom, $urandom, $urandom);
      drive(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) != 0));
      n_checks++; if (ifc.es_allowin !== (!m_valid || ifc.ms_allowin) || ifc.es_to_ms_valid !== m_valid)
        begin n_errors++; $display("FAIL rnd_hs[%0d] got allowin=%b valid=%b exp %b/%b", n, ifc.es_allowin, ifc.es_to_ms_valid, !m_valid || ifc.ms_allowin, m_valid); end
      if (m_valid) begin
        r = ref_alu(m_ins); ld = m_ins[123]; gw = m_ins[118]; mw = m_ins[117]; d = m_ins[116:112];
        en_e = ifc.ms_allowin && (ld || mw);
        n_checks++; if (ifc.es_to_ms_bus !== {ld, gw, d, r, m_ins[31:0]})
          begin n_errors++; $display("FAIL rnd_ms_bus[%0d] got %h exp %h", n, ifc.es_to_ms_bus, {ld, gw, d, r, m_ins[31:0]}); end
        n_checks++; if (ifc.es_fwd_blk_bus !== {gw && !ld && d != 0, d, r, ld && d != 0})
          begin n_errors++; $display("FAIL rnd_fwd[%0d] got %h exp %h", n, ifc.es_fwd_blk_bus, {gw && !ld && d != 0, d, r, ld && d != 0}); end
        n_checks++; if (ifc.data_sram_en !== en_e || ifc.data_sram_wen !== ((ifc.ms_allowin && mw) ? 4'hf : 4'h0)
                        || ifc.data_sram_addr !== r || ifc.data_sram_wdata !== m_ins[63:32])
          begin n_errors++; $display("FAIL rnd_sram[%0d] got en=%b wen=%h addr=%h wdata=%h exp en=%b addr=%h wdata=%h", n, ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr, ifc.data_sram_wdata, en_e, r, m_ins[63:32]); end
      end else begin
        n_checks++; if (ifc.data_sram_en !== 1'b0 || ifc.data_sram_wen !== 4'h0 || ifc.es_fwd_blk_bus[38] !== 1'b0 || ifc.es_fwd_blk_bus[0] !== 1'b0)
          begin n_errors++; $display("FAIL rnd_empty[%0d] got en=%b wen=%h fwd=%b blk=%b exp all 0", n, ifc.data_sram_en, ifc.data_sram_wen, ifc.es_fwd_blk_bus[38], ifc.es_fwd_blk_bus[0]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_stall();
    drive(1'b1, mk(OP_ADD, 0, 0, 0, 1, 0, 0, 1, 5'd0, 16'h0010, 32'h3000, 32'h12345678, 32'h0), 1'b1);
    tick();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (ifc.es_to_ms_valid !== 1'b1 || ifc.es_allowin !== 1'b0) begin n_errors++; $display("FAIL rs_stalled got valid=%b allowin=%b exp 1/0", ifc.es_to_ms_valid, ifc.es_allowin); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    drive(1'b0, '0, 1'b1);
    n_checks++; if (ifc.es_to_ms_valid !== 1'b0 || ifc.data_sram_wen !== 4'h0 || ifc.es_allowin !== 1'b1)
      begin n_errors++; $display("FAIL rs_cleared got valid=%b wen=%h allowin=%b exp 0/0/1", ifc.es_to_ms_valid, ifc.data_sram_wen, ifc.es_allowin); end
    tick();
  endtask

  initial begin
    m_valid = 1'b0;
    m_ins   = '0;
    resetn  = 1'b0;
    ifc.ds_to_es_valid = 1'b0;
    ifc.ds_to_es_bus   = '0;
    ifc.ms_allowin     = 1'b0;
    @(negedge clk);
    test_reset();
    test_addu();
    test_sw_stall();
    test_lw();
    test_jal();
    test_shift_cmp();
    test_random();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
